axi_lite_reg_router: RTL and testbench

- Sits between the AXI Lite slave's simple user register interface and NUM_CLIENTS peripheral register banks.
- Decodes each register transaction by address window and dispatches it to exactly one client as a one-cycle strobe.
- Waits for that client's acknowledge, or a timeout, then returns the ack/ready strobe, read data and invalid-address flag upstream.
- Serialises all accesses: at most one transaction in flight.

---
 rtl/axi_lite_reg_router_if.sv | 43 ++++
 rtl/axi_lite_reg_router.sv | 178 +++++++++++++++++
 tb/tb_axi_lite_reg_router.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_reg_router_if.sv
// Register-bus bundle between the upstream AXI Lite register port, the router and its clients.
// Signal directions are named from the router's point of view.
interface axi_lite_reg_router_if #(
   parameter int unsigned ADDR_WIDTH       = 16,
   parameter int unsigned DATA_WIDTH       = 32,
   parameter int unsigned NUM_CLIENTS      = 4,
   parameter int unsigned CLIENT_ADDR_BITS = 12
);
   // upstream side
   logic                              i_reg_in_rdy;
   logic                              o_reg_in_ack_stb;
   logic [ADDR_WIDTH-1:0]             i_reg_address;
   logic [DATA_WIDTH-1:0]             i_reg_in_data;
   logic                              i_reg_out_req;
   logic                              o_reg_out_rdy_stb;
   logic [DATA_WIDTH-1:0]             o_reg_out_data;
   logic                              o_reg_invalid_addr;
   // client side
   logic [NUM_CLIENTS-1:0]            o_cl_wr_stb;
   logic [NUM_CLIENTS-1:0]            o_cl_rd_stb;
   logic [CLIENT_ADDR_BITS-1:0]       o_cl_addr;
   logic [DATA_WIDTH-1:0]             o_cl_wdata;
   logic [NUM_CLIENTS-1:0]            i_cl_ack;
   logic [NUM_CLIENTS*DATA_WIDTH-1:0] i_cl_rdata;
   logic [NUM_CLIENTS-1:0]            i_cl_err;
   // status
   logic                              o_busy;
   logic                              o_timeout_stb;

   modport slave (
      input  i_reg_in_rdy, i_reg_address, i_reg_in_data, i_reg_out_req,
             i_cl_ack, i_cl_rdata, i_cl_err,
      output o_reg_in_ack_stb, o_reg_out_rdy_stb, o_reg_out_data, o_reg_invalid_addr,
             o_cl_wr_stb, o_cl_rd_stb, o_cl_addr, o_cl_wdata, o_busy, o_timeout_stb
   );

   modport master (
      output i_reg_in_rdy, i_reg_address, i_reg_in_data, i_reg_out_req,
             i_cl_ack, i_cl_rdata, i_cl_err,
      input  o_reg_in_ack_stb, o_reg_out_rdy_stb, o_reg_out_data, o_reg_invalid_addr,
             o_cl_wr_stb, o_cl_rd_stb, o_cl_addr, o_cl_wdata, o_busy, o_timeout_stb
   );
endinterface

// File: rtl/axi_lite_reg_router.sv
// Routes single upstream register accesses to one of NUM_CLIENTS banks by address window,
// waits for the bank's ack (or a timeout) and returns the result upstream. One access in flight.
module axi_lite_reg_router #(
   parameter int unsigned ADDR_WIDTH       = 16,
   parameter int unsigned DATA_WIDTH       = 32,
   parameter int unsigned NUM_CLIENTS      = 4,
   parameter int unsigned CLIENT_ADDR_BITS = 12,
   parameter int unsigned TIMEOUT          = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   axi_lite_reg_router_if.slave  bus
);

   localparam int unsigned IDX_W = ADDR_WIDTH - CLIENT_ADDR_BITS;
   localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DISPATCH,
      S_WAIT_ACK,
      S_RESPOND,
      S_WAIT_RELEASE
   } state_t;

   state_t                      r_state;
   logic                        r_is_wr;
   logic [NUM_CLIENTS-1:0]      r_sel;
   logic [TO_W-1:0]             r_cnt;

   logic                        r_in_ack_stb;
   logic                        r_out_rdy_stb;
   logic [DATA_WIDTH-1:0]       r_out_data;
   logic                        r_invalid;
   logic [NUM_CLIENTS-1:0]      r_cl_wr_stb;
   logic [NUM_CLIENTS-1:0]      r_cl_rd_stb;
   logic [CLIENT_ADDR_BITS-1:0] r_cl_addr;
   logic [DATA_WIDTH-1:0]       r_cl_wdata;
   logic                        r_busy;
   logic                        r_timeout_stb;

   logic [IDX_W-1:0]            w_idx;
   logic [NUM_CLIENTS-1:0]      w_onehot;
   logic                        w_decode_err;
   logic                        w_req;
   logic                        w_hit_ack;
   logic                        w_hit_err;
   logic                        w_timeout;
   logic [DATA_WIDTH-1:0]       w_rdata;

   assign w_idx        = bus.i_reg_address[ADDR_WIDTH-1:CLIENT_ADDR_BITS];
   assign w_decode_err = (32'(w_idx) >= NUM_CLIENTS);
   assign w_req        = bus.i_reg_in_rdy | bus.i_reg_out_req;

   // Only the latched client's ack/err count; everything else on the bus is ignored.
   assign w_hit_ack    = |(bus.i_cl_ack & r_sel);
   assign w_hit_err    = |(bus.i_cl_err & r_sel);
   assign w_timeout    = (TIMEOUT != 0) && (r_cnt == TO_W'(TIMEOUT - 1));

   always_comb begin
      w_onehot = '0;
      for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
         w_onehot[k] = (32'(w_idx) == k);
      end
   end

   always_comb begin
      w_rdata = '0;
      for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
         if (r_sel[k]) begin
            w_rdata = bus.i_cl_rdata[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Timeout counter reads 0 during DISPATCH, so a client gets TIMEOUT cycles from its strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_is_wr       <= 1'b0;
         r_sel         <= '0;
         r_cnt         <= '0;
         r_in_ack_stb  <= 1'b0;
         r_out_rdy_stb <= 1'b0;
         r_out_data    <= '0;
         r_invalid     <= 1'b0;
         r_cl_wr_stb   <= '0;
         r_cl_rd_stb   <= '0;
         r_cl_addr     <= '0;
         r_cl_wdata    <= '0;
         r_busy        <= 1'b0;
         r_timeout_stb <= 1'b0;
      end else begin
         r_cl_wr_stb   <= '0;
         r_cl_rd_stb   <= '0;
         r_in_ack_stb  <= 1'b0;
         r_out_rdy_stb <= 1'b0;
         r_timeout_stb <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_is_wr    <= bus.i_reg_in_rdy;
                  r_cl_addr  <= bus.i_reg_address[CLIENT_ADDR_BITS-1:0];
                  r_cl_wdata <= bus.i_reg_in_data;
                  r_cnt      <= '0;
                  r_busy     <= 1'b1;
                  if (w_decode_err) begin
                     r_sel         <= '0;
                     r_in_ack_stb  <= bus.i_reg_in_rdy;
                     r_out_rdy_stb <= ~bus.i_reg_in_rdy;
                     r_out_data    <= '0;
                     r_invalid     <= 1'b1;
                     r_state       <= S_RESPOND;
                  end else begin
                     r_sel <= w_onehot;
                     if (bus.i_reg_in_rdy) begin
                        r_cl_wr_stb <= w_onehot;
                     end else begin
                        r_cl_rd_stb <= w_onehot;
                     end
                     r_state <= S_DISPATCH;
                  end
               end
            end

            S_DISPATCH, S_WAIT_ACK: begin
               if (w_hit_ack) begin
                  r_out_data    <= r_is_wr ? '0 : w_rdata;
                  r_invalid     <= w_hit_err;
                  r_in_ack_stb  <= r_is_wr;
                  r_out_rdy_stb <= ~r_is_wr;
                  r_state       <= S_RESPOND;
               end else if (w_timeout) begin
                  r_out_data    <= '0;
                  r_invalid     <= 1'b1;
                  r_in_ack_stb  <= r_is_wr;
                  r_out_rdy_stb <= ~r_is_wr;
                  r_timeout_stb <= 1'b1;
                  r_state       <= S_RESPOND;
               end else begin
                  r_cnt   <= r_cnt + TO_W'(1);
                  r_state <= S_WAIT_ACK;
               end
            end

            S_RESPOND: begin
               r_state <= S_WAIT_RELEASE;
            end

            // Upstream holds its level after the strobe; wait for it to drop before re-arming.
            S_WAIT_RELEASE: begin
               if (!w_req) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_reg_in_ack_stb   = r_in_ack_stb;
   assign bus.o_reg_out_rdy_stb  = r_out_rdy_stb;
   assign bus.o_reg_out_data     = r_out_data;
   assign bus.o_reg_invalid_addr = r_invalid;
   assign bus.o_cl_wr_stb        = r_cl_wr_stb;
   assign bus.o_cl_rd_stb        = r_cl_rd_stb;
   assign bus.o_cl_addr          = r_cl_addr;
   assign bus.o_cl_wdata         = r_cl_wdata;
   assign bus.o_busy             = r_busy;
   assign bus.o_timeout_stb      = r_timeout_stb;

endmodule

// File: tb/tb_axi_lite_reg_router.sv
// Self-checking bench for axi_lite_reg_router: directed scenarios plus randomized accesses
// compared against a cycle-count reference model of the routing rules.
module tb_axi_lite_reg_router;

   localparam int unsigned AW  = 16;
   localparam int unsigned DW  = 32;
   localparam int unsigned NC  = 4;
   localparam int unsigned CAB = 12;
   localparam int unsigned TO  = 256;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axi_lite_reg_router_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CLIENTS(NC),
                            .CLIENT_ADDR_BITS(CAB)) bus ();

   axi_lite_reg_router #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CLIENTS(NC),
                         .CLIENT_ADDR_BITS(CAB), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // client bank models: delay = cycles from strobe to ack, -1 = never acks
   int              cl_delay [NC];
   logic [DW-1:0]   cl_rdata [NC];
   logic [NC-1:0]   cl_err_v   = '0;
   logic [NC-1:0]   noise_mask = '0;
   logic [NC-1:0]   noise      = '0;
   bit              noise_rand = 1'b0;
   logic [NC-1:0]   act        = '0;
   int              cnt [NC];
   logic [NC-1:0]   cl_stb;

   assign cl_stb = bus.o_cl_wr_stb | bus.o_cl_rd_stb;

   always @(posedge clk) begin
      for (int k = 0; k < int'(NC); k++) begin
         if (cl_stb[k] && cl_delay[k] > 0) begin
            act[k] <= 1'b1;
            cnt[k] <= 1;
         end else if (act[k]) begin
            if (cl_delay[k] < 0 || cnt[k] == cl_delay[k]) act[k] <= 1'b0;
            else cnt[k] <= cnt[k] + 1;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < int'(NC); k++) begin
         bus.i_cl_ack[k] = noise[k] | (cl_stb[k] && cl_delay[k] == 0) |
                           (act[k] && cnt[k] == cl_delay[k]);
         bus.i_cl_rdata[k*DW +: DW] = cl_rdata[k];
      end
      bus.i_cl_err = cl_err_v;
   end

   // Acks from clients other than the target, to prove they are ignored.
   always @(negedge clk) noise = noise_mask & (noise_rand ? NC'($urandom) : {NC{1'b1}});

   // observations of one transaction, cycles counted from the request cycle N
   int            o_stb_cyc, o_nstb, o_resp_cyc, o_nresp, o_to_cyc;
   logic [NC-1:0] o_mask;
   logic          o_stb_wr, o_resp_wr, o_resp_rd, o_inv, o_busy_drop, o_busy_after, o_inv_end;
   logic [CAB-1:0] o_cl_addr;
   logic [DW-1:0] o_cl_wdata, o_data, o_data_end;

   task automatic sample(input int c);
      if (cl_stb != '0) begin
         o_nstb += $countones(cl_stb);
         if (o_stb_cyc < 0) begin
            o_stb_cyc  = c;
            o_mask     = cl_stb;
            o_stb_wr   = (bus.o_cl_wr_stb != '0);
            o_cl_addr  = bus.o_cl_addr;
            o_cl_wdata = bus.o_cl_wdata;
         end
      end
      if (bus.o_timeout_stb && o_to_cyc < 0) o_to_cyc = c;
      if (bus.o_reg_in_ack_stb || bus.o_reg_out_rdy_stb) begin
         o_nresp++;
         if (o_resp_cyc < 0) begin
            o_resp_cyc = c;
            o_resp_wr  = bus.o_reg_in_ack_stb;
            o_resp_rd  = bus.o_reg_out_rdy_stb;
            o_data     = bus.o_reg_out_data;
            o_inv      = bus.o_reg_invalid_addr;
         end
      end
   endtask

   // Raise the request, observe until the response plus `hold` cycles, then release.
   task automatic run_txn(input logic wr, input logic rd, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input int hold);
      int c;
      o_stb_cyc = -1; o_nstb = 0; o_resp_cyc = -1; o_nresp = 0; o_to_cyc = -1;
      o_mask = '0; o_stb_wr = 1'b0; o_resp_wr = 1'b0; o_resp_rd = 1'b0; o_inv = 1'b0;
      o_busy_drop = 1'b0; o_cl_addr = '0; o_cl_wdata = '0; o_data = '0;
      @(negedge clk);
      bus.i_reg_in_rdy  = wr;
      bus.i_reg_out_req = rd;
      bus.i_reg_address = addr;
      bus.i_reg_in_data = wd;
      c = 0;
      while (c < int'(TO) + 8 && (o_resp_cyc < 0 || c < o_resp_cyc + hold)) begin
         @(negedge clk);
         c++;
         sample(c);
         if (!bus.o_busy) o_busy_drop = 1'b1;
      end
      bus.i_reg_in_rdy  = 1'b0;
      bus.i_reg_out_req = 1'b0;
      @(negedge clk);
      c++;
      sample(c);
      o_busy_after = bus.o_busy;
      o_data_end   = bus.o_reg_out_data;
      o_inv_end    = bus.o_reg_invalid_addr;
   endtask

   // Reference: what the router should return for a request, from the routing rules.
   task automatic model(input logic wr, input logic [AW-1:0] addr,
                        output int e_stb, output logic [NC-1:0] e_mask, output int e_resp,
                        output logic [DW-1:0] e_data, output logic e_inv, output int e_to);
      int idx = int'(addr) / (1 << CAB);
      if (idx >= int'(NC)) begin
         e_stb = -1; e_mask = '0; e_resp = 1; e_data = '0; e_inv = 1'b1; e_to = -1;
      end else begin
         e_stb  = 1;
         e_mask = NC'(1 << idx);
         if (cl_delay[idx] >= 0 && cl_delay[idx] < int'(TO)) begin
            e_resp = cl_delay[idx] + 2;
            e_data = wr ? '0 : cl_rdata[idx];
            e_inv  = cl_err_v[idx];
            e_to   = -1;
         end else begin
            e_resp = int'(TO) + 1;
            e_data = '0;
            e_inv  = 1'b1;
            e_to   = int'(TO) + 1;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({bus.o_reg_in_ack_stb, bus.o_reg_out_rdy_stb, bus.o_reg_out_data, bus.o_reg_invalid_addr,
           bus.o_cl_wr_stb, bus.o_cl_rd_stb, bus.o_cl_addr, bus.o_cl_wdata, bus.o_busy,
           bus.o_timeout_stb} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b data=%h stb=%b/%b, required all zero",
                  bus.o_busy, bus.o_reg_out_data, bus.o_cl_wr_stb, bus.o_cl_rd_stb);
      end
      rst = 1'b0;
   endtask

   task automatic test_write_same_cycle();
      cl_delay[2] = 0; cl_err_v[2] = 1'b0;
      run_txn(1'b1, 1'b0, 16'h2010, 32'hCAFEF00D, 2);
      n_checks++;
      if (o_stb_cyc !== 1 || o_mask !== 4'b0100 || o_stb_wr !== 1'b1 || o_nstb !== 1) begin
         n_fail++;
         $display("FAIL wr_strobe: cyc=%0d mask=%b wr=%b n=%0d, required 1/0100/1/1",
                  o_stb_cyc, o_mask, o_stb_wr, o_nstb);
      end
      n_checks++;
      if (o_cl_addr !== 12'h010 || o_cl_wdata !== 32'hCAFEF00D) begin
         n_fail++;
         $display("FAIL wr_payload: addr=%h wdata=%h, required 010/cafef00d", o_cl_addr, o_cl_wdata);
      end
      n_checks++;
      if (o_resp_cyc !== 2 || o_resp_wr !== 1'b1 || o_resp_rd !== 1'b0 || o_inv !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_ack: cyc=%0d ack=%b rdy=%b inv=%b, required 2/1/0/0",
                  o_resp_cyc, o_resp_wr, o_resp_rd, o_inv);
      end
   endtask

   task automatic test_read_delayed();
      cl_delay[1] = 3; cl_rdata[1] = 32'h12345678; cl_err_v[1] = 1'b0;
      cl_delay[0] = -1; cl_rdata[0] = 32'hDEADBEEF; cl_err_v[0] = 1'b1;
      noise_mask = 4'b0001; noise_rand = 1'b0;
      run_txn(1'b0, 1'b1, 16'h1004, 32'h0, 1);
      noise_mask = '0;
      n_checks++;
      if (o_mask !== 4'b0010 || o_stb_wr !== 1'b0 || o_nstb !== 1) begin
         n_fail++;
         $display("FAIL rd_strobe: mask=%b wr=%b n=%0d, required 0010/0/1", o_mask, o_stb_wr, o_nstb);
      end
      n_checks++;
      if (o_resp_cyc !== 5 || o_resp_rd !== 1'b1 || o_nresp !== 1) begin
         n_fail++;
         $display("FAIL rd_rdy: cyc=%0d rdy=%b n=%0d, required 5/1/1", o_resp_cyc, o_resp_rd, o_nresp);
      end
      n_checks++;
      if (o_data !== 32'h12345678 || o_inv !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_data: data=%h inv=%b, required 12345678/0", o_data, o_inv);
      end
   endtask

   task automatic test_decode_error();
      run_txn(1'b0, 1'b1, 16'h5000, 32'h0, 1);
      n_checks++;
      if (o_nstb !== 0 || o_resp_cyc !== 1 || o_resp_rd !== 1'b1) begin
         n_fail++;
         $display("FAIL dec_resp: nstb=%0d cyc=%0d rdy=%b, required 0/1/1", o_nstb, o_resp_cyc, o_resp_rd);
      end
      n_checks++;
      if (o_data !== 32'h0 || o_inv !== 1'b1 || o_to_cyc !== -1) begin
         n_fail++;
         $display("FAIL dec_flags: data=%h inv=%b to=%0d, required 0/1/-1", o_data, o_inv, o_to_cyc);
      end
   endtask

   task automatic test_timeout();
      cl_delay[3] = -1; cl_err_v[3] = 1'b0;
      run_txn(1'b1, 1'b0, 16'h3ABC, 32'h5555AAAA, 1);
      n_checks++;
      if (o_to_cyc !== int'(TO) + 1 || o_resp_cyc !== int'(TO) + 1 || o_resp_wr !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_cyc: to=%0d ack=%0d wr=%b, required %0d/%0d/1",
                  o_to_cyc, o_resp_cyc, o_resp_wr, TO + 1, TO + 1);
      end
      n_checks++;
      if (o_inv !== 1'b1 || o_nstb !== 1 || o_mask !== 4'b1000) begin
         n_fail++;
         $display("FAIL timeout_flags: inv=%b nstb=%0d mask=%b, required 1/1/1000", o_inv, o_nstb, o_mask);
      end
   endtask

   task automatic test_hold_and_priority();
      cl_delay[1] = 1; cl_rdata[1] = 32'hA5A5_0F0F; cl_err_v[1] = 1'b1;
      run_txn(1'b0, 1'b1, 16'h1100, 32'h0, 10);
      n_checks++;
      if (o_nstb !== 1 || o_nresp !== 1 || o_busy_drop !== 1'b0 || o_busy_after !== 1'b0) begin
         n_fail++;
         $display("FAIL hold: nstb=%0d nresp=%0d busy_drop=%b busy_after=%b, required 1/1/0/0",
                  o_nstb, o_nresp, o_busy_drop, o_busy_after);
      end
      n_checks++;
      if (o_data_end !== 32'hA5A5_0F0F || o_inv_end !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_data: data=%h inv=%b, required a5a50f0f/1", o_data_end, o_inv_end);
      end
      cl_delay[0] = 2; cl_err_v[0] = 1'b0;
      run_txn(1'b1, 1'b1, 16'h0040, 32'h0BADF00D, 3);
      n_checks++;
      if (o_stb_wr !== 1'b1 || o_mask !== 4'b0001 || o_nstb !== 1 || o_resp_wr !== 1'b1 ||
          o_resp_rd !== 1'b0 || o_resp_cyc !== 4) begin
         n_fail++;
         $display("FAIL priority: wr=%b mask=%b nstb=%0d ack=%b rdy=%b cyc=%0d, required 1/0001/1/1/0/4",
                  o_stb_wr, o_mask, o_nstb, o_resp_wr, o_resp_rd, o_resp_cyc);
      end
   endtask

   task automatic test_reset_mid_txn();
      int seen = 0;
      cl_delay[2] = 5; cl_rdata[2] = 32'h0000_BEEF; cl_err_v[2] = 1'b0;
      @(negedge clk);
      bus.i_reg_out_req = 1'b1;
      bus.i_reg_address = 16'h2000;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      bus.i_reg_out_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({bus.o_reg_in_ack_stb, bus.o_reg_out_rdy_stb, bus.o_reg_out_data, bus.o_reg_invalid_addr,
           bus.o_cl_wr_stb, bus.o_cl_rd_stb, bus.o_cl_addr, bus.o_cl_wdata, bus.o_busy,
           bus.o_timeout_stb} !== '0) begin
         n_fail++;
         $display("FAIL midrst_outputs: got busy=%b addr=%h stb=%b, required all zero",
                  bus.o_busy, bus.o_cl_addr, bus.o_cl_rd_stb);
      end
      rst = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (bus.o_reg_in_ack_stb || bus.o_reg_out_rdy_stb || cl_stb != '0) seen++;
      end
      n_checks++;
      if (seen !== 0) begin
         n_fail++;
         $display("FAIL midrst_late_ack: %0d strobe cycles, required 0", seen);
      end
      cl_delay[2] = 1;
      run_txn(1'b0, 1'b1, 16'h2004, 32'h0, 1);
      n_checks++;
      if (o_resp_cyc !== 3 || o_data !== 32'h0000_BEEF || o_inv !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_next: cyc=%0d data=%h inv=%b, required 3/0000beef/0",
                  o_resp_cyc, o_data, o_inv);
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 40; t++) begin
         int              idx  = $urandom_range(0, 5);
         logic            wr   = 1'($urandom_range(0, 1));
         logic            rd   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
         logic [AW-1:0]   addr = {4'(idx), 12'($urandom)};
         logic [DW-1:0]   wd   = $urandom;
         int              e_stb, e_resp, e_to;
         logic [NC-1:0]   e_mask;
         logic [DW-1:0]   e_data;
         logic            e_inv;
         for (int k = 0; k < int'(NC); k++) begin
            cl_delay[k] = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 6));
            cl_rdata[k] = $urandom;
            cl_err_v[k] = 1'($urandom_range(0, 1));
         end
         noise_rand = 1'b1;
         noise_mask = NC'($urandom) & ~((idx < int'(NC)) ? NC'(1 << idx) : NC'(0));
         model(wr, addr, e_stb, e_mask, e_resp, e_data, e_inv, e_to);
         run_txn(wr, rd, addr, wd, $urandom_range(1, 4));
         noise_mask = '0;
         n_checks++;
         if (o_stb_cyc !== e_stb || o_mask !== e_mask || o_nstb !== (e_stb > 0 ? 1 : 0) ||
             (e_stb > 0 && o_stb_wr !== wr)) begin
            n_fail++;
            $display("FAIL rnd%0d_strobe: cyc=%0d mask=%b n=%0d wr=%b, required %0d/%b/wr=%b",
                     t, o_stb_cyc, o_mask, o_nstb, o_stb_wr, e_stb, e_mask, wr);
         end
         if (e_stb > 0) begin
            n_checks++;
            if (o_cl_addr !== addr[CAB-1:0] || o_cl_wdata !== wd) begin
               n_fail++;
               $display("FAIL rnd%0d_payload: addr=%h wdata=%h, required %h/%h",
                        t, o_cl_addr, o_cl_wdata, addr[CAB-1:0], wd);
            end
         end
         n_checks++;
         if (o_resp_cyc !== e_resp || o_resp_wr !== wr || o_resp_rd !== !wr || o_nresp !== 1) begin
            n_fail++;
            $display("FAIL rnd%0d_resp: cyc=%0d ack=%b rdy=%b n=%0d, required %0d/%b/%b/1",
                     t, o_resp_cyc, o_resp_wr, o_resp_rd, o_nresp, e_resp, wr, !wr);
         end
         n_checks++;
         if (o_data !== e_data || o_inv !== e_inv || o_to_cyc !== e_to ||
             o_data_end !== e_data || o_inv_end !== e_inv) begin
            n_fail++;
            $display("FAIL rnd%0d_result: data=%h inv=%b to=%0d end=%h/%b, required %h/%b/%0d",
                     t, o_data, o_inv, o_to_cyc, o_data_end, o_inv_end, e_data, e_inv, e_to);
         end
         n_checks++;
         if (o_busy_drop !== 1'b0 || o_busy_after !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd%0d_busy: drop=%b after=%b, required 0/0", t, o_busy_drop, o_busy_after);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      bus.i_reg_in_rdy  = 1'b0;
      bus.i_reg_out_req = 1'b0;
      bus.i_reg_address = '0;
      bus.i_reg_in_data = '0;
      for (int k = 0; k < int'(NC); k++) begin
         cl_delay[k] = -1;
         cl_rdata[k] = '0;
         cnt[k]      = 0;
      end
      test_reset();
      test_write_same_cycle();
      test_read_delayed();
      test_decode_error();
      test_timeout();
      test_hold_and_priority();
      test_reset_mid_txn();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
